// File: rtl/mindy_pkg.sv
// Shared constants and helpers for the mindy fan-out block.
package mindy_pkg;

  localparam int MINDY_DATA_WBITS = 512;
  localparam int MINDY_CNT_W      = 32;

  // Address width needed to index 'value' entries; returns at least 1 for value >= 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mindy_fwft_fifo.sv
// First-word fall-through FIFO; head entry is presented whenever the FIFO is non-empty.
module mindy_fwft_fifo
  import mindy_pkg::*;
#(
  parameter int DATA_WBITS = MINDY_DATA_WBITS,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WBITS-1:0] wr_data,
  output logic                  full,
  output logic [DATA_WBITS-1:0] rd_tdata,
  output logic                  rd_tvalid,
  input  logic                  rd_tready
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_WBITS-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  // Pointers carry one extra wrap bit: equal addresses with differing MSB means full.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign rd_tvalid = !empty;
  assign rd_tdata  = mem[rd_ptr[AW-1:0]];
  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_tvalid && rd_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mindy_fanout.sv
// Broadcasts meta-data beats to NUM_OUT buffered channels and forwards frame data,
// optionally through a 2-entry skid buffer.
module mindy_fanout
  import mindy_pkg::*;
#(
  parameter int DATA_WBITS = MINDY_DATA_WBITS,
  parameter int NUM_OUT    = 2,
  parameter int MD_DEPTH   = 16,
  parameter int FD_REG     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WBITS-1:0]         AXIS_FD_IN_TDATA,
  input  logic                          AXIS_FD_IN_TVALID,
  output logic                          AXIS_FD_IN_TREADY,
  input  logic [DATA_WBITS-1:0]         AXIS_MD_IN_TDATA,
  input  logic                          AXIS_MD_IN_TVALID,
  output logic                          AXIS_MD_IN_TREADY,
  input  logic [NUM_OUT-1:0]            ch_enable,
  output logic [NUM_OUT*DATA_WBITS-1:0] AXIS_MD_OUT_TDATA,
  output logic [NUM_OUT-1:0]            AXIS_MD_OUT_TVALID,
  input  logic [NUM_OUT-1:0]            AXIS_MD_OUT_TREADY,
  output logic [DATA_WBITS-1:0]         AXIS_FD_OUT_TDATA,
  output logic                          AXIS_FD_OUT_TVALID,
  input  logic                          AXIS_FD_OUT_TREADY,
  output logic [MINDY_CNT_W-1:0]        md_accepted
);

  // Handshake rule on every stream: a beat transfers on a rising clk edge where
  // TVALID and TREADY are both high; once raised, TVALID and TDATA hold until then.

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] wr_en;
  logic               md_fire;

  // Only registered full flags feed ready; downstream TREADY never reaches the input.
  assign AXIS_MD_IN_TREADY = !reset && (&(~full | ~ch_enable));
  assign md_fire           = AXIS_MD_IN_TVALID && AXIS_MD_IN_TREADY;
  assign wr_en             = {NUM_OUT{md_fire}} & ch_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_accepted <= '0;
    end else if (md_fire) begin
      md_accepted <= md_accepted + MINDY_CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
    mindy_fwft_fifo #(
      .DATA_WBITS (DATA_WBITS),
      .DEPTH      (MD_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en[i]),
      .wr_data   (AXIS_MD_IN_TDATA),
      .full      (full[i]),
      .rd_tdata  (AXIS_MD_OUT_TDATA[i*DATA_WBITS +: DATA_WBITS]),
      .rd_tvalid (AXIS_MD_OUT_TVALID[i]),
      .rd_tready (AXIS_MD_OUT_TREADY[i])
    );
  end

  if (FD_REG != 0) begin : g_fd_skid
    logic [DATA_WBITS-1:0] out_data;
    logic [DATA_WBITS-1:0] skid_data;
    logic                  out_valid;
    logic                  skid_valid;
    logic                  in_ready;

    // in_ready mirrors "skid entry empty" as a register, held low through reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        in_ready   <= 1'b0;
      end else if (!out_valid || AXIS_FD_OUT_TREADY) begin
        in_ready   <= 1'b1;
        skid_valid <= 1'b0;
        if (skid_valid) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else begin
          out_data  <= AXIS_FD_IN_TDATA;
          out_valid <= AXIS_FD_IN_TVALID && in_ready;
        end
      end else if (AXIS_FD_IN_TVALID && in_ready) begin
        skid_data  <= AXIS_FD_IN_TDATA;
        skid_valid <= 1'b1;
        in_ready   <= 1'b0;
      end
    end

    assign AXIS_FD_IN_TREADY  = in_ready;
    assign AXIS_FD_OUT_TDATA  = out_data;
    assign AXIS_FD_OUT_TVALID = out_valid;
  end else begin : g_fd_wire
    assign AXIS_FD_IN_TREADY  = AXIS_FD_OUT_TREADY;
    assign AXIS_FD_OUT_TDATA  = AXIS_FD_IN_TDATA;
    assign AXIS_FD_OUT_TVALID = AXIS_FD_IN_TVALID;
  end

endmodule

// File: tb/tb_mindy_fanout.sv
// Directed bench for mindy_fanout: broadcast, backpressure, masking, wrap, reset and frame path.
module tb_mindy_fanout;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   fd_in_tdata;
  logic           fd_in_tvalid;
  logic           fd_in_tready;
  logic [W-1:0]   md_in_tdata;
  logic           md_in_tvalid;
  logic           md_in_tready;
  logic [N-1:0]   ch_enable;
  logic [N*W-1:0] md_out_tdata;
  logic [N-1:0]   md_out_tvalid;
  logic [N-1:0]   md_out_tready;
  logic [W-1:0]   fd_out_tdata;
  logic           fd_out_tvalid;
  logic           fd_out_tready;
  logic [31:0]    md_accepted;

  int checks = 0;
  int errors = 0;
  int md_stalls = 0;
  int fd_stalls = 0;
  int out_cnt [N];
  logic fd_rand = 1'b0;

  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  logic [W-1:0] fd_exp = '0;
  logic [W-1:0] fd_hold = '0;
  logic         fd_stalled = 1'b0;

  mindy_fanout #(
    .DATA_WBITS (W),
    .NUM_OUT    (N),
    .MD_DEPTH   (D),
    .FD_REG     (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .AXIS_FD_IN_TDATA   (fd_in_tdata),
    .AXIS_FD_IN_TVALID  (fd_in_tvalid),
    .AXIS_FD_IN_TREADY  (fd_in_tready),
    .AXIS_MD_IN_TDATA   (md_in_tdata),
    .AXIS_MD_IN_TVALID  (md_in_tvalid),
    .AXIS_MD_IN_TREADY  (md_in_tready),
    .ch_enable          (ch_enable),
    .AXIS_MD_OUT_TDATA  (md_out_tdata),
    .AXIS_MD_OUT_TVALID (md_out_tvalid),
    .AXIS_MD_OUT_TREADY (md_out_tready),
    .AXIS_FD_OUT_TDATA  (fd_out_tdata),
    .AXIS_FD_OUT_TVALID (fd_out_tvalid),
    .AXIS_FD_OUT_TREADY (fd_out_tready),
    .md_accepted        (md_accepted)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: hold a meta-data beat until accepted; leaves TVALID high for back-to-back use.
  task automatic send_md(input logic [W-1:0] d);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    md_in_tdata  = d;
    md_in_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = md_in_tready;
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          if (ch_enable[i]) exp_q[i].push_back(d);
        end
      end else begin
        n++;
        md_stalls++;
      end
      @(posedge clk); #1;
    end
    chk("md_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_fd(input logic [W-1:0] d);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    fd_in_tdata  = d;
    fd_in_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = fd_in_tready;
      if (!acc) begin
        n++;
        fd_stalls++;
      end
      @(posedge clk); #1;
      if (fd_rand) fd_out_tready = 1'($urandom_range(0, 1));
    end
    chk("fd_accept", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int cycles);
    md_in_tvalid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk_drained(input string tag);
    for (int i = 0; i < N; i++) chk(tag, 64'(exp_q[i].size()), 64'd0);
  endtask

  // Scoreboard: every meta-data output beat must match the head of its channel queue.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (md_out_tvalid[i] && md_out_tready[i]) begin
          mon_got = md_out_tdata[i*W +: W];
          if (exp_q[i].size() == 0) begin
            checks++;
            assert (0) else begin
              errors++;
              $error("FAIL md_extra ch%0d: observed beat %0h expected none", i, mon_got);
            end
          end else begin
            mon_exp = exp_q[i].pop_front();
            chk($sformatf("md_data_ch%0d", i), 64'(mon_got), 64'(mon_exp));
            out_cnt[i]++;
          end
        end
      end
    end
  end

  // Frame-path monitor: strictly incrementing data, held stable across stalls.
  always @(negedge clk) begin
    if (!reset) begin
      if (fd_stalled) begin
        chk("fd_hold_valid", 64'(fd_out_tvalid), 64'd1);
        chk("fd_hold_data", 64'(fd_out_tdata), 64'(fd_hold));
      end
      if (fd_out_tvalid && fd_out_tready) begin
        chk("fd_data", 64'(fd_out_tdata), 64'(fd_exp));
        fd_exp = fd_exp + 1;
      end
      fd_stalled = fd_out_tvalid && !fd_out_tready;
      fd_hold    = fd_out_tdata;
    end
  end

  initial begin
    reset         = 1'b1;
    fd_in_tdata   = '0;
    fd_in_tvalid  = 1'b0;
    md_in_tdata   = '0;
    md_in_tvalid  = 1'b0;
    ch_enable     = 4'b1111;
    md_out_tready = 4'b1111;
    fd_out_tready = 1'b1;
    foreach (out_cnt[i]) out_cnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_md_in_ready", 64'(md_in_tready), 64'd0);
    chk("rst_fd_in_ready", 64'(fd_in_tready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_md_valid", 64'(md_out_tvalid), 64'd0);
    chk("rst_fd_valid", 64'(fd_out_tvalid), 64'd0);
    chk("rst_count", 64'(md_accepted), 64'd0);

    // Broadcast 0x01..0x05 to all channels
    send_md(32'h01);
    chk("bc_latency_valid", 64'(md_out_tvalid), 64'hF);
    for (int i = 0; i < N; i++) chk("bc_latency_data", 64'(md_out_tdata[i*W +: W]), 64'h01);
    for (int k = 2; k <= 5; k++) send_md(W'(k));
    idle(4);
    chk("bc_count", 64'(md_accepted), 64'd5);
    chk_drained("bc_drained");
    for (int i = 0; i < N; i++) chk("bc_out_cnt", 64'(out_cnt[i]), 64'd5);

    // Backpressure: ch1 stalled fills after 16 beats
    md_out_tready = 4'b1101;
    for (int k = 1; k <= 16; k++) send_md(W'(32'h100 + k));
    md_in_tdata  = 32'h111;
    md_in_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(md_in_tready), 64'd0);
    end
    chk("bp_ch1_valid", 64'(md_out_tvalid[1]), 64'd1);
    chk("bp_ch1_head", 64'(md_out_tdata[1*W +: W]), 64'h101);
    @(posedge clk); #1;
    md_out_tready = 4'b1111;
    for (int k = 17; k <= 20; k++) send_md(W'(32'h100 + k));
    idle(24);
    chk("bp_count", 64'(md_accepted), 64'd25);
    chk_drained("bp_drained");
    for (int i = 0; i < N; i++) chk("bp_out_cnt", 64'(out_cnt[i]), 64'd25);

    // Mask: only ch0 and ch2 receive
    ch_enable = 4'b0101;
    send_md(32'hAA);
    send_md(32'hBB);
    chk("mask_valid", 64'(md_out_tvalid), 64'h5);
    chk("mask_data_ch2", 64'(md_out_tdata[2*W +: W]), 64'hBB);
    ch_enable = 4'b0000;
    md_stalls = 0;
    for (int k = 0; k < 3; k++) send_md(W'(32'hC1 + k));
    idle(3);
    chk("mask_none_stalls", 64'(md_stalls), 64'd0);
    chk("mask_none_valid", 64'(md_out_tvalid), 64'd0);
    chk("mask_count", 64'(md_accepted), 64'd30);
    chk("mask_cnt_ch0", 64'(out_cnt[0]), 64'd27);
    chk("mask_cnt_ch1", 64'(out_cnt[1]), 64'd25);

    // Wrap: 1000 beats back-to-back with zero stalls
    ch_enable = 4'b1111;
    md_stalls = 0;
    for (int k = 0; k < 1000; k++) send_md(W'(32'h1000 + k));
    idle(4);
    chk("wrap_stalls", 64'(md_stalls), 64'd0);
    chk("wrap_count", 64'(md_accepted), 64'd1030);
    chk_drained("wrap_drained");
    chk("wrap_cnt_ch3", 64'(out_cnt[3]), 64'd1025);

    // Reset mid-run discards buffered beats
    md_out_tready = 4'b0000;
    for (int k = 0; k < 3; k++) send_md(W'(32'h61 + k));
    idle(1);
    chk("mid_pre_valid", 64'(md_out_tvalid), 64'hF);
    chk("mid_pre_count", 64'(md_accepted), 64'd1033);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    chk("mid_valid", 64'(md_out_tvalid), 64'd0);
    chk("mid_count", 64'(md_accepted), 64'd0);
    send_md(32'h77);
    md_in_tvalid = 1'b0;
    chk("mid_first_valid", 64'(md_out_tvalid), 64'hF);
    for (int i = 0; i < N; i++) chk("mid_first_data", 64'(md_out_tdata[i*W +: W]), 64'h77);
    chk("mid_count_after", 64'(md_accepted), 64'd1);
    md_out_tready = 4'b1111;
    idle(3);
    chk_drained("mid_drained");

    // Frame path with random downstream ready
    fd_rand = 1'b1;
    for (int k = 0; k < 64; k++) send_fd(W'(k));
    fd_in_tvalid  = 1'b0;
    fd_rand       = 1'b0;
    fd_out_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("fd_rand_total", 64'(fd_exp), 64'd64);
    chk("fd_rand_empty", 64'(fd_out_tvalid), 64'd0);

    // Frame path throughput with ready held high
    fd_stalls = 0;
    for (int k = 64; k < 128; k++) send_fd(W'(k));
    fd_in_tvalid = 1'b0;
    @(negedge clk); #1;
    chk("fd_tp_stalls", 64'(fd_stalls), 64'd0);
    chk("fd_tp_total", 64'(fd_exp), 64'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mindy_fanout.md
Name: mindy_fanout

Overview:
- Generalised successor of the two-way meta-data/frame-data interface block: broadcasts each meta-data beat to NUM_OUT independent output streams, each buffered by its own internal FIFO of MD_DEPTH entries.
- Adds a run-time channel-enable mask, an optional registered (skid-buffered) frame-data path, and an accepted-beat counter.
- Sits between the frame/meta-data producers and the downstream consumers (DMA/record engines) in the mindy core.

Parameters:
- DATA_WBITS, 512, width of frame-data and meta-data TDATA.
- NUM_OUT, 2, number of meta-data output channels; 1..8.
- MD_DEPTH, 16, entries per meta-data FIFO; power of 2, >=2.
- FD_REG, 1, 1 = frame path through 2-entry skid buffer; 0 = combinational pass-through.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- AXIS_FD_IN_TDATA/TVALID/TREADY  in/in/out  DATA_WBITS/1/1  frame-data input stream.
- AXIS_MD_IN_TDATA/TVALID/TREADY  in/in/out  DATA_WBITS/1/1  meta-data input stream.
- ch_enable  in  NUM_OUT  per-channel meta-data enable mask.
- AXIS_MD_OUT_TDATA  out  NUM_OUT*DATA_WBITS  channel i occupies bits [i*DATA_WBITS +: DATA_WBITS].
- AXIS_MD_OUT_TVALID  out  NUM_OUT  per-channel valid.
- AXIS_MD_OUT_TREADY  in  NUM_OUT  per-channel ready.
- AXIS_FD_OUT_TDATA/TVALID/TREADY  out/out/in  DATA_WBITS/1/1  frame-data output stream.
- md_accepted  out  32  count of accepted meta-data input beats; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, active-high): all FIFOs empty; AXIS_MD_OUT_TVALID=0; AXIS_FD_OUT_TVALID=0; md_accepted=0.
- During reset: AXIS_MD_IN_TREADY=0; AXIS_FD_IN_TREADY=0 when FD_REG=1.
- Reset mid-operation discards all buffered data; no partial beat is ever emitted.
- MD input ready: AXIS_MD_IN_TREADY = !reset & AND over i of (!full[i] | !ch_enable[i]).
  - Registered full flags only; no combinational path from any AXIS_MD_OUT_TREADY.
- MD handshake (TVALID & TREADY): beat written to every FIFO i with ch_enable[i]=1 in that same cycle; md_accepted increments by 1.
- ch_enable=0 (all channels): input always ready; beats are dropped but still counted.
- Disabled channel keeps draining its existing entries normally; re-enabling takes effect on the next handshake.
- FIFO: first-word fall-through.
  - TVALID[i] = !empty[i]; TDATA = head entry.
  - Latency from input handshake in cycle N to TVALID[i]=1 in cycle N+1.
- FIFO pointers are log2(MD_DEPTH)+1 bits and wrap naturally.
  - full when addresses are equal and the MSB differs; empty when pointers are fully equal.
- Simultaneous read and write on one FIFO: occupancy unchanged. Allowed when not full.
- When full, a write is refused even if a read occurs in the same cycle, because ready does not look ahead.
- Channels drain independently; a stalled channel blocks input only when it is full and enabled.
- Per-channel beat ordering is preserved; no duplication or loss on enabled channels.
- FD_REG=0: FD_OUT = FD_IN wires; FD_IN_TREADY = FD_OUT_TREADY.
- FD_REG=1: 2-entry skid buffer.
  - AXIS_FD_IN_TREADY is registered (= skid entry empty).
  - Latency 1 cycle; sustains 1 beat/clk with downstream always ready.
  - TDATA held stable while TVALID & !TREADY.
- AXIS TVALID outputs never depend combinationally on the TREADY inputs.

Decomposition:
- Shared package mindy_pkg: constant MINDY_DATA_WBITS=512; function clog2 helper; md_accepted width constant MINDY_CNT_W=32.
- One natural sub-module, mindy_fwft_fifo (DATA_WBITS, DEPTH).
  - Ports: clk, reset, wr_en, wr_data, full, rd_tdata, rd_tvalid, rd_tready.
  - Instantiated NUM_OUT times via generate.
- Skid buffer stays inline in mindy_fanout.

Test Plan:
- Broadcast: NUM_OUT=4, ch_enable=4'b1111, send beats 0x01..0x05, all TREADY=1 -> each channel emits 0x01..0x05 in order, each beat 1 cycle after its handshake; md_accepted=5.
- Backpressure: MD_DEPTH=16, ch1 TREADY=0, others 1, send 20 beats.
  - Expected: MD_IN_TREADY drops after beat 16; ch1 holds 16 entries.
  - Then raise ch1 TREADY: remaining 4 beats accepted; every channel emits exactly 20 beats.
- Mask: ch_enable=4'b0101, send 0xAA, 0xBB -> only ch0 and ch2 emit them; ch1/ch3 TVALID stay 0.
  - Then ch_enable=0, send 3 beats -> all accepted and dropped; md_accepted=5.
- Wrap and concurrency: MD_DEPTH=4, all TREADY=1, stream 1000 incrementing beats back-to-back -> zero stalls, data exact, pointers wrap without loss.
- Reset mid-run: fill ch0 with 3 beats, assert reset 1 cycle -> all TVALID=0 and md_accepted=0 the next cycle; the following beat 0x77 emerges first on every enabled channel.
- Frame path: FD_REG=1, stream 0..63 while toggling FD_OUT_TREADY pseudo-randomly -> output is 0..63 in order, no duplicates, TDATA stable while stalled; throughput is 64 beats in 64 cycles with ready held high.
